imem_loader: RTL and testbench

- Boot-time program loader: the writer side of the instruction-memory path that the rv32i core reads through pc[6:2].
- Accepts a byte stream over a valid/ready handshake, typically from a UART receiver.
- Assembles little-endian 32-bit words and writes them to consecutive word addresses of the memory block's write port.
- Holds the core in reset until the image is complete; releases it only on a clean load.

---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/loader_word_asm.sv | 43 ++++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared loader state encoding and stream framing constants
package rv32i_pkg;

   // Loader FSM states; CKSUM is only reachable with IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      HDR0,
      HDR1,
      DATA,
      WRITE,
      CKSUM,
      DONE,
      ERR
   } loader_state_t;

   // Word-count header is two bytes, little-endian
   localparam int HDR_BYTES = 2;

   // Instruction words are assembled from four bytes, LSB first
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_word_asm.sv
// rtl/loader_word_asm.sv - byte-to-word shift register for the instruction loader
module loader_word_asm
   import rv32i_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        accept,
   input  logic [7:0]  data,
   output logic        word_ready,
   output logic [31:0] word
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [31:0] shreg;
   logic [1:0]  idx;

   // Word as it stands including the byte arriving this cycle, so the
   // writer can capture a complete word on the edge that takes byte 3
   always_comb begin
      word = shreg;
      if (accept) begin
         word[{idx, 3'b000} +: 8] = data;
      end
   end

   assign word_ready = accept && (idx == LAST_IDX);

   // Store accepted bytes; a completed word clears the register for the next one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         idx   <= '0;
      end else if (word_ready) begin
         shreg <= '0;
         idx   <= '0;
      end else if (accept) begin
         shreg <= word;
         idx   <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a byte stream into instruction memory (option: IMEM_LOADER_CHECKSUM_EN)
module imem_loader
   import rv32i_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   localparam logic [31:0]      DEPTH   = 32'(1) << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   loader_state_t    state;
   logic [7:0]       n_lo;
   logic [CNT_W-1:0] n_words;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hdr_n;
   logic             xfer;
   logic             data_accept;
   logic             word_ready;
   logic [31:0]      word;

   assign xfer        = rx_valid && rx_ready;
   assign data_accept = xfer && (state == DATA);
   assign hdr_n       = CNT_W'({rx_data, n_lo});

   loader_word_asm u_word_asm (
      .clk        (clk),
      .rst        (rst),
      .accept     (data_accept),
      .data       (rx_data),
      .word_ready (word_ready),
      .word       (word)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] cksum;

   // Running XOR over every accepted data byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cksum <= '0;
      end else if (data_accept) begin
         cksum <= cksum ^ rx_data;
      end
   end
`endif

   // Load sequencer; all outputs are registered against the state being entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HDR0;
         n_lo      <= '0;
         n_words   <= '0;
         cnt       <= '0;
         rx_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rst   <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            HDR0: begin
               rx_ready <= 1'b1;
               if (xfer) begin
                  n_lo  <= rx_data;
                  state <= HDR1;
               end
            end
            HDR1: begin
               if (xfer) begin
                  n_words <= hdr_n;
                  if (hdr_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state <= CKSUM;
`else
                     state    <= DONE;
                     rx_ready <= 1'b0;
                     done     <= 1'b1;
                     cpu_rst  <= 1'b0;
`endif
                  end else if (32'(hdr_n) > DEPTH) begin
                     state <= ERR;
                     err   <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (word_ready) begin
                  state     <= WRITE;
                  rx_ready  <= 1'b0;
                  mem_we    <= 1'b1;
                  mem_addr  <= cnt[ADDR_W-1:0];
                  mem_wdata <= word;
               end
            end
            WRITE: begin
               cnt <= cnt + CNT_ONE;
               if (cnt == n_words - CNT_ONE) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state    <= CKSUM;
                  rx_ready <= 1'b1;
`else
                  state   <= DONE;
                  done    <= 1'b1;
                  cpu_rst <= 1'b0;
`endif
               end else begin
                  state    <= DATA;
                  rx_ready <= 1'b1;
               end
            end
            CKSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (xfer) begin
                  if (rx_data == cksum) begin
                     state    <= DONE;
                     rx_ready <= 1'b0;
                     done     <= 1'b1;
                     cpu_rst  <= 1'b0;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
`else
               state <= ERR;
               err   <= 1'b1;
`endif
            end
            DONE: begin
               rx_ready <= 1'b0;
            end
            ERR: begin
               rx_ready <= 1'b1;
            end
            default: begin
               state <= ERR;
               err   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (IMEM_LOADER_CHECKSUM_EN aware)
module tb_imem_loader;

   localparam int ADDR_W = 5;
   localparam int CNT_W  = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cyc = -1;
   int ready_bad = 0;
   bit loading = 1'b0;
   int          wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_cyc_q[$];

   imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Memory-port monitor, sampled on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (mem_we) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
         end
         if (done && done_cyc < 0) done_cyc = cyc;
         if (loading && !done && !err && !mem_we && !rx_ready) ready_bad++;
      end
   end

   // Reference framing: header, words LSB first, optional XOR trailer
   function automatic bq_t build_stream(input int n, input wq_t words);
      bq_t s;
      logic [7:0] x;
      logic [15:0] nn;
      logic [31:0] w;
      x = 8'h00;
      nn = 16'(n);
      s.push_back(nn[7:0]);
      s.push_back(nn[15:8]);
      foreach (words[i]) begin
         w = words[i];
         for (int b = 0; b < 4; b++) begin
            s.push_back(w[8*b +: 8]);
            x = x ^ w[8*b +: 8];
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(x);
`endif
      return s;
   endfunction

   task automatic do_reset;
      rx_valid = 1'b0;
      loading = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      done_cyc = -1;
      ready_bad = 0;
   endtask

   // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
   task automatic send_stream(input bq_t s, input int mode, output int lost);
      lost = 0;
      foreach (s[i]) begin
         int gap;
         int waited;
         gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
         repeat (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
         end
         rx_valid = 1'b1;
         rx_data = s[i];
         waited = 0;
         while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
         end
         if (rx_ready) @(negedge clk);
         else lost++;
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err} !==
          {1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_values: got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b expected 0 0 0 0 1 0 0",
                  rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({rx_ready, cpu_rst, done} !== 3'b110) begin
         n_bad++;
         $display("FAIL post_reset_hdr0: got rdy/crst/done=%b expected 110", {rx_ready, cpu_rst, done});
      end
   endtask

   task automatic test_basic(input int mode, input string tag);
      bq_t s;
      int lost;
      int nwr;
      s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(8'h13 ^ 8'h05 ^ 8'h10 ^ 8'h93 ^ 8'h05 ^ 8'h20);
`endif
      do_reset();
      loading = 1'b1;
      send_stream(s, mode, lost);
      repeat (3) @(negedge clk);
      loading = 1'b0;
      n_cmp++;
      if (wr_addr_q.size() !== 2 || lost !== 0) begin
         n_bad++;
         $display("FAIL %s_count: got writes=%0d lost=%0d expected 2 and 0", tag, wr_addr_q.size(), lost);
      end
      if (wr_addr_q.size() == 2) begin
         n_cmp++;
         if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 32'h00100513 ||
             wr_addr_q[1] !== 1 || wr_data_q[1] !== 32'h00200593) begin
            n_bad++;
            $display("FAIL %s_writes: got %0d:%h %0d:%h expected 0:00100513 1:00200593",
                     tag, wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
         end
`ifndef IMEM_LOADER_CHECKSUM_EN
         n_cmp++;
         if (done_cyc !== wr_cyc_q[1] + 1) begin
            n_bad++;
            $display("FAIL %s_release_timing: got done cycle %0d expected %0d", tag, done_cyc, wr_cyc_q[1] + 1);
         end
`endif
      end
      n_cmp++;
      if ({done, cpu_rst, err} !== 3'b100) begin
         n_bad++;
         $display("FAIL %s_final: got done/crst/err=%b expected 100", tag, {done, cpu_rst, err});
      end
      n_cmp++;
      if (ready_bad !== 0) begin
         n_bad++;
         $display("FAIL %s_ready_gaps: got %0d non-write stall cycles expected 0", tag, ready_bad);
      end
      // Bytes offered after DONE must not be taken
      nwr = wr_addr_q.size();
      rx_valid = 1'b1;
      rx_data = 8'hAA;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_after_done_ready: got %b expected 0", tag, rx_ready);
         end
      end
      rx_valid = 1'b0;
      n_cmp++;
      if (wr_addr_q.size() !== nwr) begin
         n_bad++;
         $display("FAIL %s_after_done_writes: got %0d expected %0d", tag, wr_addr_q.size(), nwr);
      end
   endtask

   task automatic test_loads(input int n_fixed, input int iters);
      for (int t = 0; t < iters; t++) begin
         int n;
         int lost;
         int bad;
         wq_t w;
         n = (n_fixed > 0) ? n_fixed : int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++) w.push_back($urandom);
         do_reset();
         loading = 1'b1;
         send_stream(build_stream(n, w), 2, lost);
         repeat (3) @(negedge clk);
         loading = 1'b0;
         n_cmp++;
         if (wr_addr_q.size() !== n || lost !== 0) begin
            n_bad++;
            $display("FAIL load%0d_count: got writes=%0d lost=%0d expected %0d and 0", n, wr_addr_q.size(), lost, n);
         end
         bad = 0;
         for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== i || wr_data_q[i] !== w[i]) begin
               if (bad == 0)
                  $display("FAIL load%0d_word%0d: got %0d:%h expected %0d:%h", n, i, wr_addr_q[i], wr_data_q[i], i, w[i]);
               bad++;
            end
         end
         n_cmp++;
         if (bad !== 0) n_bad++;
         n_cmp++;
         if ({done, cpu_rst, err, ready_bad == 0} !== 4'b1001) begin
            n_bad++;
            $display("FAIL load%0d_final: got done/crst/err=%b stalls=%0d expected 100 and 0",
                     n, {done, cpu_rst, err}, ready_bad);
         end
      end
   endtask

   task automatic test_overflow;
      wq_t w;
      int lost;
      for (int i = 0; i < 5; i++) w.push_back($urandom);
      do_reset();
      send_stream(build_stream(DEPTH + 1, w), 0, lost);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (lost !== 0 || wr_addr_q.size() !== 0) begin
         n_bad++;
         $display("FAIL overflow_drain: got lost=%0d writes=%0d expected 0 and 0", lost, wr_addr_q.size());
      end
      n_cmp++;
      if ({err, cpu_rst, done, rx_ready} !== 4'b1101) begin
         n_bad++;
         $display("FAIL overflow_flags: got err/crst/done/rdy=%b expected 1101", {err, cpu_rst, done, rx_ready});
      end
   endtask

   task automatic test_zero_length;
      wq_t w;
      int lost;
      do_reset();
      send_stream(build_stream(0, w), 0, lost);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (wr_addr_q.size() !== 0 || {done, cpu_rst, err} !== 3'b100 || lost !== 0) begin
         n_bad++;
         $display("FAIL zero_length: got writes=%0d done/crst/err=%b lost=%0d expected 0 100 0",
                  wr_addr_q.size(), {done, cpu_rst, err}, lost);
      end
   endtask

   task automatic test_reset_mid;
      wq_t w;
      bq_t s;
      int lost;
      w.push_back($urandom | 32'h1);
      w.push_back($urandom);
      s = build_stream(2, w);
      do_reset();
      send_stream(s[0:7], 0, lost);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err} !==
          {1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_mid_async: got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b expected 0 0 0 0 1 0 0",
                  rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err);
      end
      w.delete();
      w.push_back($urandom);
      do_reset();
      send_stream(build_stream(1, w), 0, lost);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (wr_addr_q.size() !== 1 || done !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_mid_reload: got writes=%0d done=%b expected 1 and 1", wr_addr_q.size(), done);
      end else begin
         n_cmp++;
         if (wr_addr_q[0] !== 0 || wr_data_q[0] !== w[0]) begin
            n_bad++;
            $display("FAIL reset_mid_word: got %0d:%h expected 0:%h", wr_addr_q[0], wr_data_q[0], w[0]);
         end
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum;
      bq_t s;
      int lost;
      s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06};
      do_reset();
      send_stream(s, 0, lost);
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({done, err, cpu_rst} !== 3'b100) begin
         n_bad++;
         $display("FAIL cksum_good: got done/err/crst=%b expected 100", {done, err, cpu_rst});
      end
      s[6] = 8'h07;
      do_reset();
      send_stream(s, 0, lost);
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({done, err, cpu_rst} !== 3'b011) begin
         n_bad++;
         $display("FAIL cksum_bad: got done/err/crst=%b expected 011", {done, err, cpu_rst});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic(0, "basic");
      test_basic(1, "toggle");
      test_loads(DEPTH, 1);
      test_loads(0, 4);
      test_overflow();
      test_zero_length();
      test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not reach summary");
      $fatal(1, "timeout");
   end

endmodule
